// File: rtl/frontend_output_arbiter.sv
// Merges N_BLOCKS event streams and the time tag stream into one registered output word.
// Tags win outright; events are served round-robin, and stall holds tags off while events drain.
module frontend_output_arbiter #(
  parameter int DATA_BITS  = 128,
  parameter int N_BLOCKS   = 4,
  parameter int STALL_MAX  = 1023,
  parameter int COUNT_BITS = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_BLOCKS*DATA_BITS-1:0]   ev_data,
  input  logic [N_BLOCKS-1:0]             ev_valid,
  output logic [N_BLOCKS-1:0]             ev_ready,
  input  logic [DATA_BITS-1:0]            tt_data,
  input  logic                            tt_valid,
  output logic                            tt_ready,
  output logic                            stall,
  output logic [DATA_BITS-1:0]            out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [COUNT_BITS-1:0]           ev_count_last
);

  localparam int PTR_W = $clog2(N_BLOCKS);
  localparam int SC_W  = $clog2(STALL_MAX + 1);
  localparam logic [SC_W-1:0]       SC_MAX  = SC_W'(STALL_MAX);
  localparam logic [COUNT_BITS-1:0] CNT_SAT = '1;
  localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(N_BLOCKS - 1);

  logic                   load;
  logic                   ev_acc;
  logic                   any_ev;
  logic                   tt_hold;
  logic [PTR_W-1:0]       ptr;
  logic [PTR_W-1:0]       grant_idx;
  logic [PTR_W-1:0]       ptr_nxt;
  logic [N_BLOCKS-1:0]    grant;
  logic [SC_W-1:0]        stall_cnt;
  logic [COUNT_BITS-1:0]  ev_count;
  logic [DATA_BITS-1:0]   ev_sel;

  function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= N_BLOCKS) s = s - N_BLOCKS;
    return PTR_W'(s);
  endfunction

  // First valid block at or after ptr, wrapping modulo N_BLOCKS
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_ev    = 1'b0;
    for (int k = 0; k < N_BLOCKS; k++) begin
      if (!any_ev && ev_valid[rr_idx(ptr, k)]) begin
        any_ev                 = 1'b1;
        grant_idx              = rr_idx(ptr, k);
        grant[rr_idx(ptr, k)]  = 1'b1;
      end
    end
  end

  always_comb begin
    ev_sel = '0;
    for (int i = 0; i < N_BLOCKS; i++) begin
      if (grant[i]) ev_sel = ev_data[i*DATA_BITS +: DATA_BITS];
    end
  end

  assign ptr_nxt  = (grant_idx == PTR_LAST) ? '0 : grant_idx + PTR_W'(1);
  assign load     = ~out_valid | out_ready;
  assign tt_ready = load & tt_valid;
  assign ev_ready = (load & ~tt_valid) ? grant : '0;
  assign ev_acc   = |ev_ready;

  // stall never looks at tt_valid, which breaks the loop through the tag counter
  assign stall = ~tt_hold & (|ev_valid) & (stall_cnt != SC_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      ptr           <= '0;
      stall_cnt     <= '0;
      tt_hold       <= 1'b0;
      ev_count      <= '0;
      ev_count_last <= '0;
    end else begin
      if (tt_ready) begin
        out_data      <= tt_data;
        out_valid     <= 1'b1;
        ev_count_last <= ev_count;
        ev_count      <= '0;
      end else if (ev_acc) begin
        out_data  <= ev_sel;
        out_valid <= 1'b1;
        ptr       <= ptr_nxt;
        if (ev_count != CNT_SAT) ev_count <= ev_count + COUNT_BITS'(1);
      end else if (load) begin
        out_valid <= 1'b0;
      end

      if (stall) stall_cnt <= stall_cnt + SC_W'(1);
      else       stall_cnt <= '0;

      // A tag already released by the counter must not be stalled again
      if (tt_valid & ~tt_ready)     tt_hold <= 1'b1;
      else if (tt_valid & tt_ready) tt_hold <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frontend_output_arbiter.sv
// Directed bench for frontend_output_arbiter with STALL_MAX=7 and 32-bit words.
// The bench plays the time tag counter: it raises tt_valid only while stall is low.
module tb_frontend_output_arbiter;

  localparam int DW = 32;
  localparam int NB = 4;
  localparam int SM = 7;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NB*DW-1:0]  ev_data;
  logic [NB-1:0]     ev_valid;
  logic [NB-1:0]     ev_ready;
  logic [DW-1:0]     tt_data;
  logic              tt_valid;
  logic              tt_ready;
  logic              stall;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     ev_count_last;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ptr;
  logic pending;
  logic [DW-1:0] last_word;

  frontend_output_arbiter #(
    .DATA_BITS(DW), .N_BLOCKS(NB), .STALL_MAX(SM), .COUNT_BITS(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .ev_data(ev_data), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .tt_data(tt_data), .tt_valid(tt_valid), .tt_ready(tt_ready),
    .stall(stall),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ev_count_last(ev_count_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] word(input int i);
    return DW'(32'hE000_0000 + i);
  endfunction

  function automatic logic [NB-1:0] onehot(input int i);
    logic [NB-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < NB; i++) ev_data[i*DW +: DW] = word(i);
    rst = 1'b1; ev_valid = '0; tt_data = '0; tt_valid = 1'b0; out_ready = 1'b1;
    pending = 1'b0; last_word = '0; exp_ptr = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_count_last", 64'(ev_count_last), 64'(0));
    chk("rst_stall", 64'(stall), 64'(0));
    chk("rst_ev_ready", 64'(ev_ready), 64'(0));

    // Idle events: tag passes in the same cycle
    tt_data = 32'h7A60_0001; tt_valid = 1'b1; #1;
    chk("idle_stall", 64'(stall), 64'(0));
    chk("idle_tt_ready", 64'(tt_ready), 64'(1));
    tick(); tt_valid = 1'b0; #1;
    chk("idle_tag_valid", 64'(out_valid), 64'(1));
    chk("idle_tag_data", 64'(out_data), 64'(32'h7A60_0001));
    chk("idle_count_last", 64'(ev_count_last), 64'(0));
    tick();
    chk("idle_drained", 64'(out_valid), 64'(0));

    // Round robin, all blocks valid, no tags: stall high 7 then low 1
    ev_valid = 4'hF; #1;
    for (int c = 0; c < 8; c++) begin
      chk("rr_ev_ready", 64'(ev_ready), 64'(onehot(c % NB)));
      chk("rr_stall", 64'(stall), 64'(c < 7));
      tick();
      chk("rr_out_valid", 64'(out_valid), 64'(1));
      chk("rr_out_data", 64'(out_data), 64'(word(c % NB)));
    end

    // Stall window with a tag pending; accepted in the low cycle (8 + 7 events before it)
    exp_ptr = 0; pending = 1'b1; tt_data = 32'h7A60_0002;
    for (int c = 0; c < 9; c++) begin
      tt_valid = pending & ~stall; #1;
      chk("win_stall", 64'(stall), 64'(c != 7));
      if (c == 7) begin
        chk("win_tt_ready", 64'(tt_ready), 64'(1));
        chk("win_ev_blocked", 64'(ev_ready), 64'(0));
      end else begin
        chk("win_ev_ready", 64'(ev_ready), 64'(onehot(exp_ptr)));
      end
      tick();
      if (c == 7) begin
        chk("win_tag_data", 64'(out_data), 64'(32'h7A60_0002));
        chk("win_count_last", 64'(ev_count_last), 64'(15));
        pending = 1'b0;
      end else begin
        chk("win_ev_data", 64'(out_data), 64'(word(exp_ptr)));
        exp_ptr = (exp_ptr + 1) % NB;
      end
    end

    // Next window (stall_cnt already 1): backpressure for 3 cycles in the low cycle
    pending = 1'b1; tt_data = 32'h7A60_0003;
    for (int c = 0; c < 10; c++) begin
      out_ready = !(c >= 6 && c <= 8);
      tt_valid = pending & ~stall; #1;
      chk("bp_stall", 64'(stall), 64'(c < 6));
      if (c >= 6) begin
        chk("bp_ev_blocked", 64'(ev_ready), 64'(0));
        chk("bp_tt_ready", 64'(tt_ready), 64'(c == 9));
      end else begin
        chk("bp_ev_ready", 64'(ev_ready), 64'(onehot(exp_ptr)));
      end
      tick();
      if (c < 6) begin
        last_word = word(exp_ptr);
        chk("bp_ev_data", 64'(out_data), 64'(last_word));
        exp_ptr = (exp_ptr + 1) % NB;
      end else if (c < 9) begin
        chk("bp_hold_valid", 64'(out_valid), 64'(1));
        chk("bp_hold_data", 64'(out_data), 64'(last_word));
      end else begin
        chk("bp_tag_data", 64'(out_data), 64'(32'h7A60_0003));
        chk("bp_count_last", 64'(ev_count_last), 64'(7));
        pending = 1'b0;
      end
    end
    tt_valid = 1'b0; #1;
    chk("bp_hold_clear_stall", 64'(stall), 64'(1));
    chk("bp_resume_ready", 64'(ev_ready), 64'(onehot(exp_ptr)));
    ev_valid = '0;
    tick();

    // 5 events, tag, 2 events, tag
    ev_valid = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      #1 chk("cnt5_ev_ready", 64'(ev_ready), 64'(4'b0100));
      tick();
      chk("cnt5_data", 64'(out_data), 64'(word(2)));
    end
    ev_valid = '0; tt_data = 32'h7A60_0004; tt_valid = 1'b1; #1;
    chk("cnt5_tt_ready", 64'(tt_ready), 64'(1));
    tick(); tt_valid = 1'b0;
    chk("cnt5_count_last", 64'(ev_count_last), 64'(5));
    ev_valid = 4'b0011; #1;
    chk("cnt2_first_grant", 64'(ev_ready), 64'(4'b0001));
    tick();
    chk("cnt2_data0", 64'(out_data), 64'(word(0)));
    chk("cnt2_second_grant", 64'(ev_ready), 64'(4'b0010));
    tick();
    chk("cnt2_data1", 64'(out_data), 64'(word(1)));
    ev_valid = '0; tt_data = 32'h7A60_0005; tt_valid = 1'b1;
    tick(); tt_valid = 1'b0;
    chk("cnt2_count_last", 64'(ev_count_last), 64'(2));

    // Saturation of the event counter
    ev_valid = 4'hF;
    for (int c = 0; c < 65540; c++) tick();
    ev_valid = '0; tt_data = 32'h7A60_0006; tt_valid = 1'b1;
    tick(); tt_valid = 1'b0;
    chk("sat_count_last", 64'(ev_count_last), 64'(16'hFFFF));
    tick();

    // Reset while a word is held under backpressure (ptr is 2 here, block 1 wins)
    ev_valid = 4'b0010; #1;
    chk("prerst_grant", 64'(ev_ready), 64'(4'b0010));
    tick();
    ev_valid = '0; out_ready = 1'b0;
    tick();
    chk("prerst_hold_valid", 64'(out_valid), 64'(1));
    chk("prerst_hold_data", 64'(out_data), 64'(word(1)));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_out_valid", 64'(out_valid), 64'(0));
    chk("rst2_out_data", 64'(out_data), 64'(0));
    chk("rst2_count_last", 64'(ev_count_last), 64'(0));
    ev_valid = 4'hF; out_ready = 1'b1; #1;
    chk("rst2_first_grant", 64'(ev_ready), 64'(4'b0001));
    chk("rst2_stall", 64'(stall), 64'(1));
    tick();
    chk("rst2_data", 64'(out_data), 64'(word(0)));
    ev_valid = '0; tt_data = 32'h7A60_0007; tt_valid = 1'b1;
    tick(); tt_valid = 1'b0;
    chk("rst2_count_last_after", 64'(ev_count_last), 64'(1));
    tick();
    chk("final_idle", 64'(out_valid), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frontend_output_arbiter.md
# frontend_output_arbiter

Merges the per-block single-event streams and the time tag stream into the single frontend output stream ahead of the serializer. Events are served round-robin. The block drives `stall` to the time tag counter so a tag waits until pending events are drained, which keeps events ordered before the tag of the next period. Stall is bounded by `STALL_MAX` so tags are never starved. It also reports the event count between consecutive time tags.

## Interface
- `DATA_BITS`, 128: width of every event/tag word
- `N_BLOCKS`, 4: number of event sources (2..8)
- `STALL_MAX`, 1023: maximum consecutive cycles `stall` may stay high
- `COUNT_BITS`, 16: width of the event counters
- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `ev_data`  in  N_BLOCKS*DATA_BITS  event words, block i at bits [i*DATA_BITS +: DATA_BITS]
- `ev_valid`  in  N_BLOCKS  per-block event valid
- `ev_ready`  out  N_BLOCKS  per-block accept
- `tt_data`  in  DATA_BITS  time tag word
- `tt_valid`  in  1  time tag valid (already gated by `stall` in the counter)
- `tt_ready`  out  1  time tag accept
- `stall`  out  1  hold-off to the time tag counter
- `out_data`  out  DATA_BITS  merged stream word (registered)
- `out_valid`  out  1  merged stream valid (registered)
- `out_ready`  in  1  downstream accept
- `ev_count_last`  out  COUNT_BITS  events forwarded between the last two accepted tags

## Operation
- `load = ~out_valid | out_ready`. This is a 1-deep output register.
- Time tag has absolute priority: `tt_ready = load & tt_valid`.
- Event grant `g` is one-hot, combinational, and round-robin.
  - Search starts at pointer `ptr` and takes the first i (mod N_BLOCKS) with `ev_valid[i]`.
  - `ev_ready[i] = load & ~tt_valid & g[i]`.
- On any accept (tag or event): `out_data <= accepted word`, `out_valid <= 1`.
- If `load` and nothing is accepted: `out_valid <= 0`. `out_data` holds.
- On an event accept from block i: `ptr <= (i+1) mod N_BLOCKS`. Otherwise `ptr` holds.
- `stall = ~tt_hold & (|ev_valid) & (stall_cnt != STALL_MAX)`.
- `stall_cnt`:
  - if `stall`: `stall_cnt <= stall_cnt + 1`;
  - else: `stall_cnt <= 0`.
  - Width is clog2(STALL_MAX+1); the counter never wraps.
- `tt_hold`:
  - set when `tt_valid & ~tt_ready`;
  - cleared when `tt_valid & tt_ready`.
  - While set, `stall` stays low, so a tag seen in a forced window is not re-stalled.
- `ev_count`:
  - increments on each event accept, saturating at 2^COUNT_BITS-1;
  - on a tag accept: `ev_count_last <= ev_count`, `ev_count <= 0`.
  - A tag and an event cannot be accepted in the same cycle.

## Timing
- Reset values (sync `rst`):
  - `out_valid`=0, `out_data`=0, `ptr`=0, `stall_cnt`=0, `tt_hold`=0, `ev_count`=0, `ev_count_last`=0.
  - A word held in the output register at reset is discarded.
- Latency: input accepted in cycle N appears with `out_valid` in cycle N+1.
- Throughput: 1 word/cycle with `out_ready` held high.
- `out_data` and `out_valid` are stable while `out_valid & ~out_ready`.
- `stall`, `ev_ready` and `tt_ready` are combinational from registers and inputs.
  - `tt_ready` depends on `tt_valid`, which depends on `stall`. There is no loop, because `stall` does not depend on `tt_valid`.
- With events continuously valid, `stall` is high for exactly STALL_MAX cycles, then low for exactly 1 cycle.
- A tag pending in the counter becomes visible in that low cycle.
- Idle events (`ev_valid`==0): `stall`=0 and a tag passes in the same cycle it asserts `tt_valid`.
- Downstream backpressure during a tag window: `tt_hold` keeps `stall` low until the tag is accepted. Events wait meanwhile.

## Test plan
- Reset, then all `ev_valid` low and `tt_valid` pulses 1 cycle with `out_ready`=1 -> `stall`=0, `tt_ready`=1, tag on `out_data` next cycle, `ev_count_last`=0.
- All 4 blocks valid continuously, `out_ready`=1, no tags -> grants in order 0,1,2,3,0,...; one word/cycle; each word matches its source.
- STALL_MAX=7, events continuously valid, tag pending -> `stall` high 7 cycles, low 1. The tag is accepted in the low cycle and output next cycle. Events resume after.
- Same as above but `out_ready`=0 during the window for 3 cycles -> `tt_hold`=1, `stall` stays 0, `ev_ready`=0. The tag is accepted when `out_ready` returns, then `tt_hold`=0.
- 5 events, then a tag, then 2 events, then a tag -> `ev_count_last`=5 after the first tag accept and 2 after the second. Also force more than 65535 events -> saturates at 65535.
- `rst` asserted while `out_valid`=1 and `out_ready`=0 -> next cycle `out_valid`=0, `ptr`=0, `stall_cnt`=0, and block 0 is granted first after release.
